// File: rtl/video_sprite_engine.sv
// Multi-sprite overlay for the HDMI video path.
// NUM_SPR rectangles bounce inside the active area, each with a fixed colour.
// Lower sprite indices are drawn on top, and odd-index sprites blink on a frame counter.
// The pixel path is two enabled cycles deep, and sync is delayed by the same amount.
module video_sprite_engine #(
    parameter int ACTIVE_W  = 1920,
    parameter int ACTIVE_H  = 1080,
    parameter int NUM_SPR   = 4,
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 64,
    parameter int STEP      = 2,
    parameter int BLINK_PER = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cen_i,
    input  logic        vid_sel_i,
    input  logic        freeze_i,
    input  logic [23:0] vid_rgb_i,
    input  logic [1:0]  vh_blank_i,
    input  logic [2:0]  dvh_sync_i,
    output logic [2:0]  dvh_sync_o,
    output logic [23:0] vid_rgb_o,
    output logic        hit_o
);

    localparam int HW    = $clog2(ACTIVE_W);
    localparam int VW    = $clog2(ACTIVE_H);
    localparam int FW    = $clog2(BLINK_PER);
    localparam int LIM_X = ACTIVE_W - SPR_W;
    localparam int LIM_Y = ACTIVE_H - SPR_H;
    localparam int SXW   = HW + 2;
    localparam int SYW   = VW + 2;

    localparam logic [HW:0]            SPR_W_X = (HW + 1)'(SPR_W);
    localparam logic [VW:0]            SPR_H_Y = (VW + 1)'(SPR_H);
    localparam logic signed [SXW-1:0]  STEP_X  = SXW'(STEP);
    localparam logic signed [SYW-1:0]  STEP_Y  = SYW'(STEP);
    localparam logic signed [SXW-1:0]  LIM_XS  = SXW'(LIM_X);
    localparam logic signed [SYW-1:0]  LIM_YS  = SYW'(LIM_Y);

    function automatic logic [HW-1:0] init_x(input int k);
        return HW'((k * 2 * SPR_W) % LIM_X);
    endfunction

    function automatic logic [VW-1:0] init_y(input int k);
        return VW'((k * SPR_H) % LIM_Y);
    endfunction

    function automatic logic [23:0] spr_colour(input int k);
        case (k % 4)
            0:       return 24'hFFFF00;
            1:       return 24'hFF0000;
            2:       return 24'h00FF00;
            default: return 24'h0000FF;
        endcase
    endfunction

    logic [1:0]         r_blank;
    logic [HW-1:0]      r_hcnt;
    logic [VW-1:0]      r_vcnt;
    logic [FW-1:0]      r_frame_cnt;
    logic [HW-1:0]      r_pos_x [NUM_SPR];
    logic [VW-1:0]      r_pos_y [NUM_SPR];
    logic [NUM_SPR-1:0] r_dx_neg;
    logic [NUM_SPR-1:0] r_dy_neg;

    logic [NUM_SPR-1:0] r_s1_hit;
    logic [23:0]        r_s1_rgb;
    logic [2:0]         r_s1_sync;
    logic               r_s1_sel;
    logic [23:0]        r_rgb_o;
    logic [2:0]         r_sync_o;
    logic               r_hit_o;

    logic                  w_hblank_rise;
    logic                  w_vblank_rise;
    logic                  w_blink_off;
    logic [NUM_SPR-1:0]    w_hit;
    logic signed [SXW-1:0] w_sum_x [NUM_SPR];
    logic signed [SYW-1:0] w_sum_y [NUM_SPR];
    logic [HW-1:0]         w_nx [NUM_SPR];
    logic [VW-1:0]         w_ny [NUM_SPR];
    logic [NUM_SPR-1:0]    w_ndx_neg;
    logic [NUM_SPR-1:0]    w_ndy_neg;
    logic [23:0]           w_mix_rgb;

    assign w_hblank_rise = vh_blank_i[0] & ~r_blank[0];
    assign w_vblank_rise = vh_blank_i[1] & ~r_blank[1];
    // Frame counter's top bit is set exactly in the second half of the blink period.
    assign w_blink_off   = r_frame_cnt[FW-1];

    // Per-sprite coverage test of the current input pixel; blanking suppresses every hit.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_SPR; k++) begin
            w_hit[k] = ((k % 2 == 0) || !w_blink_off)
                     && (r_hcnt >= r_pos_x[k])
                     && ({1'b0, r_hcnt} < ({1'b0, r_pos_x[k]} + SPR_W_X))
                     && (r_vcnt >= r_pos_y[k])
                     && ({1'b0, r_vcnt} < ({1'b0, r_pos_y[k]} + SPR_H_Y));
        end
        if (|vh_blank_i) begin
            w_hit = '0;
        end
    end

    // Next position and direction of every sprite, clamped at the active-area walls.
    always_comb begin
        w_ndx_neg = r_dx_neg;
        w_ndy_neg = r_dy_neg;
        for (int k = 0; k < NUM_SPR; k++) begin
            w_sum_x[k] = r_dx_neg[k] ? ($signed({2'b00, r_pos_x[k]}) - STEP_X)
                                     : ($signed({2'b00, r_pos_x[k]}) + STEP_X);
            w_sum_y[k] = r_dy_neg[k] ? ($signed({2'b00, r_pos_y[k]}) - STEP_Y)
                                     : ($signed({2'b00, r_pos_y[k]}) + STEP_Y);
            w_nx[k] = w_sum_x[k][HW-1:0];
            w_ny[k] = w_sum_y[k][VW-1:0];
            if (w_sum_x[k][SXW-1] || (w_sum_x[k] == '0)) begin
                w_nx[k]      = '0;
                w_ndx_neg[k] = 1'b0;
            end else if (w_sum_x[k] >= LIM_XS) begin
                w_nx[k]      = HW'(LIM_X);
                w_ndx_neg[k] = 1'b1;
            end
            if (w_sum_y[k][SYW-1] || (w_sum_y[k] == '0)) begin
                w_ny[k]      = '0;
                w_ndy_neg[k] = 1'b0;
            end else if (w_sum_y[k] >= LIM_YS) begin
                w_ny[k]      = VW'(LIM_Y);
                w_ndy_neg[k] = 1'b1;
            end
        end
    end

    // Raster counters, blank edge detect, and once-per-frame sprite motion.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_blank     <= '0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_frame_cnt <= '0;
            for (int k = 0; k < NUM_SPR; k++) begin
                r_pos_x[k]  <= init_x(k);
                r_pos_y[k]  <= init_y(k);
                r_dx_neg[k] <= 1'b0;
                r_dy_neg[k] <= (k % 2 == 1);
            end
        end else if (cen_i) begin
            r_blank <= vh_blank_i;
            r_hcnt  <= vh_blank_i[0] ? '0 : r_hcnt + HW'(1);
            if (vh_blank_i[1]) begin
                r_vcnt <= '0;
            end else if (w_hblank_rise) begin
                r_vcnt <= r_vcnt + VW'(1);
            end
            if (w_vblank_rise && !freeze_i) begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
                for (int k = 0; k < NUM_SPR; k++) begin
                    r_pos_x[k] <= w_nx[k];
                    r_pos_y[k] <= w_ny[k];
                end
                r_dx_neg <= w_ndx_neg;
                r_dy_neg <= w_ndy_neg;
            end
        end
    end

    // Background choice, then the lowest-index hitting sprite paints over it.
    always_comb begin
        w_mix_rgb = r_s1_sel ? r_s1_rgb : 24'h000000;
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            if (r_s1_hit[k]) begin
                w_mix_rgb = spr_colour(k);
            end
        end
    end

    // Two-stage pixel pipeline: capture hits/video/sync, then register the composite.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_hit  <= '0;
            r_s1_rgb  <= '0;
            r_s1_sync <= '0;
            r_s1_sel  <= 1'b0;
            r_rgb_o   <= '0;
            r_sync_o  <= '0;
            r_hit_o   <= 1'b0;
        end else if (cen_i) begin
            r_s1_hit  <= w_hit;
            r_s1_rgb  <= vid_rgb_i;
            r_s1_sync <= dvh_sync_i;
            r_s1_sel  <= vid_sel_i;
            r_rgb_o   <= w_mix_rgb;
            r_sync_o  <= r_s1_sync;
            r_hit_o   <= |r_s1_hit;
        end
    end

    assign vid_rgb_o  = r_rgb_o;
    assign dvh_sync_o = r_sync_o;
    assign hit_o      = r_hit_o;

endmodule

// File: tb/tb_video_sprite_engine.sv
// Bench for video_sprite_engine in a small 32x16 raster with two 4x4 sprites.
// A per-pixel model of the sprite rules predicts every output. Literal pixel
// expectations, read from a captured output image, pin that model.
module tb_video_sprite_engine;

    localparam int W   = 32;
    localparam int H   = 16;
    localparam int N   = 2;
    localparam int SW  = 4;
    localparam int SH  = 4;
    localparam int ST  = 1;
    localparam int BP  = 4;
    localparam int HBL = 8;
    localparam int VBL = 4;
    localparam logic [23:0] VID = 24'h123456;

    logic        clk_i;
    logic        rst_n_i;
    logic        cen_i;
    logic        vid_sel_i;
    logic        freeze_i;
    logic [23:0] vid_rgb_i;
    logic [1:0]  vh_blank_i;
    logic [2:0]  dvh_sync_i;
    logic [2:0]  dvh_sync_o;
    logic [23:0] vid_rgb_o;
    logic        hit_o;

    video_sprite_engine #(
        .ACTIVE_W(W), .ACTIVE_H(H), .NUM_SPR(N), .SPR_W(SW), .SPR_H(SH),
        .STEP(ST), .BLINK_PER(BP)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cen_i(cen_i), .vid_sel_i(vid_sel_i),
        .freeze_i(freeze_i), .vid_rgb_i(vid_rgb_i), .vh_blank_i(vh_blank_i),
        .dvh_sync_i(dvh_sync_i), .dvh_sync_o(dvh_sync_o), .vid_rgb_o(vid_rgb_o),
        .hit_o(hit_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [27:0] e;
        int          x;
        int          y;
    } item_t;

    int          tests = 0;
    int          fails = 0;
    int          nprint = 0;
    logic        chk_en = 1'b1;
    logic        cur_sel;
    item_t       drv_item;
    item_t       q[$];
    item_t       it;
    logic [27:0] cur_e;
    int          cur_x;
    int          cur_y;
    logic [23:0] img_rgb [H][W];
    logic        img_hit [H][W];
    int          mx[N], my[N], mdx[N], mdy[N];
    int          mfc;
    int          moves;
    int          m_b;
    logic [23:0] pal [4];

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k]  = (k * 2 * SW) % (W - SW);
            my[k]  = (k * SH) % (H - SH);
            mdx[k] = 1;
            mdy[k] = (k % 2 == 0) ? 1 : -1;
        end
        mfc = 0;
    endfunction

    function automatic void axis_move(inout int p, inout int d, input int lim);
        int n;
        n = p + d * ST;
        if (n <= 0) begin
            p = 0; d = 1;
        end else if (n >= lim) begin
            p = lim; d = -1;
        end else begin
            p = n;
        end
    endfunction

    function automatic void model_move();
        mfc = (mfc + 1) % BP;
        for (int k = 0; k < N; k++) begin
            axis_move(mx[k], mdx[k], W - SW);
            axis_move(my[k], mdy[k], H - SH);
        end
    endfunction

    function automatic void model_pixel(input int x, input int y, input logic blank,
                                        output logic [23:0] rgb, output logic hit);
        int win;
        win = -1;
        if (!blank) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (((k % 2 == 0) || (mfc < BP / 2)) &&
                    x >= mx[k] && x < mx[k] + SW && y >= my[k] && y < my[k] + SH)
                    win = k;
            end
        end
        hit = (win >= 0);
        rgb = (win >= 0) ? pal[win % 4] : (cur_sel ? VID : 24'h000000);
    endfunction

    // Output checker: every enabled edge queues the prediction for the captured input;
    // the output visible after an edge is the prediction from one enabled edge earlier.
    initial begin
        cur_e = '0; cur_x = -1; cur_y = -1;
        forever begin
            @(posedge clk_i);
            if (!rst_n_i) begin
                q.delete();
                cur_e = '0; cur_x = -1; cur_y = -1;
            end else if (cen_i) begin
                q.push_back(drv_item);
                if (q.size() >= 2) begin
                    it = q.pop_front();
                    cur_e = it.e; cur_x = it.x; cur_y = it.y;
                end
            end
            #1;
            if (!rst_n_i || chk_en) begin
                tests++;
                if ({hit_o, vid_rgb_o, dvh_sync_o} !== cur_e) begin
                    fails++;
                    if (nprint < 30)
                        $display("FAIL pixel t=%0t x=%0d y=%0d got hit=%0b rgb=%06h sync=%03b want hit=%0b rgb=%06h sync=%03b",
                                 $time, cur_x, cur_y, hit_o, vid_rgb_o, dvh_sync_o,
                                 cur_e[27], cur_e[26:3], cur_e[2:0]);
                    nprint++;
                end
            end
            if (rst_n_i && cur_x >= 0 && cur_y >= 0 && cur_y < H) begin
                img_rgb[cur_y][cur_x] = vid_rgb_o;
                img_hit[cur_y][cur_x] = hit_o;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int x, input int y, input logic hb, input logic vb,
                         input logic cen, input logic frz, input logic [2:0] sy);
        logic [23:0] r;
        logic        h;
        @(negedge clk_i);
        cen_i      = cen;
        vh_blank_i = {vb, hb};
        dvh_sync_i = sy;
        vid_sel_i  = cur_sel;
        freeze_i   = frz;
        vid_rgb_i  = VID;
        model_pixel(x, y, hb | vb, r, h);
        drv_item.e = {h, r, sy};
        drv_item.x = (hb | vb) ? -1 : x;
        drv_item.y = y;
    endtask

    task automatic check_out0(input string nm);
        tests++;
        if ({hit_o, vid_rgb_o, dvh_sync_o} !== 28'd0) begin
            fails++;
            $display("FAIL %s got hit=%0b rgb=%06h sync=%03b want all zero",
                     nm, hit_o, vid_rgb_o, dvh_sync_o);
        end
    endtask

    task automatic reset_mid();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        chk_en  = 1'b0;
        #1 check_out0("reset_async");
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        cur_sel = 1'b0;
    endtask

    task automatic run_frame(input logic frz, input logic tog, input int ry, input int rx);
        logic       hb, vb, t;
        logic [2:0] sy;
        for (int y = 0; y < H + VBL; y++) begin
            for (int x = 0; x < W + HBL; x++) begin
                if (y == 0 && x == 0) chk_en = 1'b1;
                if (y == ry && x == rx) reset_mid();
                hb = (x >= W);
                vb = (y >= H);
                sy = {~(hb | vb), vb && (y == H + 1 || y == H + 2), hb && x >= W + 2 && x < W + 6};
                t  = tog && (y > 1 || (y == 1 && x >= 10));
                drive(x, y, hb, vb, 1'b1, frz, sy);
                if (t) drive(x, y, hb, vb, 1'b0, frz, sy);
                if (y == H && x == 0 && !frz) begin
                    model_move();
                    moves++;
                end
            end
        end
    endtask

    task automatic lit(input string nm, input int y, input int x,
                       input logic [23:0] er, input logic eh);
        tests++;
        if (img_rgb[y][x] !== er || img_hit[y][x] !== eh) begin
            fails++;
            $display("FAIL %s (x=%0d,y=%0d) got rgb=%06h hit=%0b want rgb=%06h hit=%0b",
                     nm, x, y, img_rgb[y][x], img_hit[y][x], er, eh);
        end
    endtask

    function automatic int sprite0_x();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                if (img_rgb[y][x] == 24'hFFFF00) return x;
        return -1;
    endfunction

    task automatic check_s0_x(input string nm, input int want);
        int got;
        got = sprite0_x();
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s moves=%0d got x=%0d want x=%0d", nm, m_b, got, want);
        end
    endtask

    task automatic scene1_checks();
        lit("s1_spr0_tl",  0,  0, 24'hFFFF00, 1'b1);
        lit("s1_spr0_br",  3,  3, 24'hFFFF00, 1'b1);
        lit("s1_right0",   0,  4, 24'h000000, 1'b0);
        lit("s1_below0",   4,  3, 24'h000000, 1'b0);
        lit("s1_spr1_tl",  4,  8, 24'hFF0000, 1'b1);
        lit("s1_spr1_br",  7, 11, 24'hFF0000, 1'b1);
        lit("s1_right1",   7, 12, 24'h000000, 1'b0);
        lit("s1_below1",   8,  8, 24'h000000, 1'b0);
    endtask

    initial begin
        pal[0] = 24'hFFFF00; pal[1] = 24'hFF0000; pal[2] = 24'h00FF00; pal[3] = 24'h0000FF;
        rst_n_i = 1'b1; cen_i = 1'b1; vh_blank_i = 2'b11; dvh_sync_i = 3'b000;
        vid_rgb_i = VID; vid_sel_i = 1'b0; freeze_i = 1'b1; cur_sel = 1'b0;
        moves = 0; m_b = 0;
        model_reset();
        drv_item.e = '0; drv_item.x = -1; drv_item.y = -1;
        #1 rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 check_out0("reset_state");
        rst_n_i = 1'b1;
        repeat (4) drive(-1, -1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);

        // Frozen, black background: sprites at their reset positions.
        run_frame(1'b1, 1'b0, -1, -1);
        scene1_checks();

        // Moving sprites over flat input video, including the wall bounce and overlap.
        cur_sel = 1'b1;
        for (int f = 0; f < 30; f++) begin
            m_b = moves;
            run_frame(1'b0, (m_b == 2), -1, -1);
            check_s0_x("s0_x", (m_b <= W - SW) ? m_b : 2 * (W - SW) - m_b);
            case (m_b)
                1: begin
                    lit("f1_spr0_at11", 1,  1, 24'hFFFF00, 1'b1);
                    lit("f1_bg_00",     0,  0, VID,        1'b0);
                    lit("f1_bg_55",     5,  5, VID,        1'b0);
                    lit("f1_spr1_vis",  4, 10, 24'hFF0000, 1'b1);
                end
                2: begin
                    lit("f2_spr0",      2,  2, 24'hFFFF00, 1'b1);
                    lit("f2_spr1_off",  4, 11, VID,        1'b0);
                end
                3: lit("f3_spr1_off",   2, 12, VID,        1'b0);
                4: lit("f4_spr1_on",    0, 12, 24'hFF0000, 1'b1);
                25: begin
                    lit("ovl_win0",     3, 25, 24'hFFFF00, 1'b1);
                    lit("ovl_win0_b",   4, 26, 24'hFFFF00, 1'b1);
                    lit("ovl_spr1",     3, 24, 24'hFF0000, 1'b1);
                end
                28: check_s0_x("wall_28", 28);
                29: check_s0_x("wall_back_27", 27);
                default: ;
            endcase
        end

        // Reset in the middle of a line, then a frozen black frame as after power-up.
        cur_sel = 1'b1;
        run_frame(1'b1, 1'b0, 5, 10);
        cur_sel = 1'b0;
        run_frame(1'b1, 1'b0, -1, -1);
        scene1_checks();

        repeat (4) drive(-1, -1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
